// File: rtl/simd_addsub_pipe_if.sv
// Operand/result bus of the SIMD add/subtract pipeline.
// Handshake: a beat moves on a rising edge where valid & ready are both high; the source holds data stable while valid is high and ready is low.
interface simd_addsub_pipe_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [1:0]     in_mode;
  logic           in_sub;
  logic           in_sat;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_y;
  logic [W/4-1:0] out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_sub, in_sat, in_signed, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_sub, in_sat, in_signed, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );
endinterface

// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD add/subtract: nibble carry chain cut at lane boundaries, then
// per-lane overflow detection and optional saturation.
module simd_addsub_pipe #(
  parameter int W = 32
) (
  input logic              clk,
  input logic              rst_n,
  simd_addsub_pipe_if.slave bus
);
  localparam int N = W / 4;

  function automatic logic nib_is_lsb(input int i, input logic [1:0] mode);
    case (mode)
      2'b00:   return 1'b1;
      2'b01:   return (i % 2) == 0;
      2'b10:   return (i % 4) == 0;
      default: return i == 0;
    endcase
  endfunction

  function automatic logic nib_is_msb(input int i, input logic [1:0] mode);
    case (mode)
      2'b00:   return 1'b1;
      2'b01:   return (i % 2) == 1;
      2'b10:   return (i % 4) == 3;
      default: return i == N - 1;
    endcase
  endfunction

  // Saturated nibble for one position of an overflowing lane.
  function automatic logic [3:0] sat_nibble(input logic msb, input logic sign_a,
                                            input logic sub, input logic sgn);
    if (sgn) begin
      if (msb) return sign_a ? 4'h8 : 4'h7;
      else     return sign_a ? 4'h0 : 4'hF;
    end
    return sub ? 4'h0 : 4'hF;
  endfunction

  logic         s1_valid;
  logic [W-1:0] s1_sum;
  logic [N-1:0] s1_cout;
  logic [N-1:0] s1_sa;
  logic [N-1:0] s1_sb;
  logic [1:0]   s1_mode;
  logic         s1_sub;
  logic         s1_sat;
  logic         s1_signed;

  logic         s2_valid;
  logic [W-1:0] s2_y;
  logic [N-1:0] s2_ovf;

  logic s1_load;
  logic s2_load;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // Stage 1: nibble adders; carry-in restarts at each lane's LSB nibble.
  logic [W-1:0] b_eff;
  logic [W-1:0] sum_c;
  logic [N-1:0] cout_c;
  logic [N-1:0] sa_c;
  logic [N-1:0] sb_c;

  always_comb begin
    logic       carry;
    logic [4:0] t;
    b_eff  = bus.in_sub ? ~bus.in_b : bus.in_b;
    sum_c  = '0;
    cout_c = '0;
    sa_c   = '0;
    sb_c   = '0;
    carry  = 1'b0;
    t      = '0;
    for (int i = 0; i < N; i++) begin
      if (nib_is_lsb(i, bus.in_mode)) carry = bus.in_sub;
      t = {1'b0, bus.in_a[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + {4'b0, carry};
      sum_c[4*i +: 4] = t[3:0];
      carry = t[4];
      if (nib_is_msb(i, bus.in_mode)) begin
        cout_c[i] = t[4];
        sa_c[i]   = bus.in_a[4*i+3];
        sb_c[i]   = b_eff[4*i+3];
      end
    end
  end

  // Stage 2: overflow found at each lane MSB and swept down over the lane.
  logic [W-1:0] y_c;
  logic [N-1:0] ovf_c;

  always_comb begin
    logic lane_ovf;
    logic lane_sa;
    logic msb;
    y_c      = s1_sum;
    ovf_c    = '0;
    lane_ovf = 1'b0;
    lane_sa  = 1'b0;
    msb      = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      msb = nib_is_msb(i, s1_mode);
      if (msb) begin
        lane_sa = s1_sa[i];
        if (s1_signed)
          lane_ovf = (s1_sa[i] == s1_sb[i]) && (s1_sum[4*i+3] != s1_sa[i]);
        else
          lane_ovf = s1_cout[i] ^ s1_sub;
        ovf_c[i] = lane_ovf;
      end
      if (lane_ovf && s1_sat)
        y_c[4*i +: 4] = sat_nibble(msb, lane_sa, s1_sub, s1_signed);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_cout   <= '0;
      s1_sa     <= '0;
      s1_sb     <= '0;
      s1_mode   <= 2'b00;
      s1_sub    <= 1'b0;
      s1_sat    <= 1'b0;
      s1_signed <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum    <= sum_c;
        s1_cout   <= cout_c;
        s1_sa     <= sa_c;
        s1_sb     <= sb_c;
        s1_mode   <= bus.in_mode;
        s1_sub    <= bus.in_sub;
        s1_sat    <= bus.in_sat;
        s1_signed <= bus.in_signed;
      end
    end
  end

  // Output register holds its data while stalled so the result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_ovf   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= y_c;
        s2_ovf <= ovf_c;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_ovf   = s2_ovf;

endmodule
